// File: rtl/dmem_access_unit_pkg.sv
// Shared encodings and defaults for the MEM-stage data memory.
package dmem_access_unit_pkg;

    localparam logic [1:0] DSIZE_BYTE = 2'b00;
    localparam logic [1:0] DSIZE_HALF = 2'b01;
    localparam logic [1:0] DSIZE_RSVD = 2'b10;
    localparam logic [1:0] DSIZE_WORD = 2'b11;

    localparam int DMEM_SIZE = 16384;

endpackage

// File: rtl/dmem_access_unit_extender.sv
// Generic zero/sign extender from inN to outN bits.
module extender #(
    parameter int inN  = 8,
    parameter int outN = 32
) (
    input  logic [inN-1:0]  in,
    input  logic            sign,
    output logic [outN-1:0] out
);

    assign out = {{(outN - inN){sign & in[inN-1]}}, in};

endmodule

// File: rtl/dmem_access_unit.sv
// Big-endian byte-addressable data memory with size-aware load/store formatting.
// Optional DMEM_ALIGN_CHECK_EN enables the misalign / sticky align_err logic.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int SIZE = DMEM_SIZE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_wr,
    input  logic [1:0]  dsize,
    input  logic        load_ext,
    output logic [31:0] dmem_out,
    output logic        misalign,
    output logic        align_err
);

    localparam int AW = $clog2(SIZE);

    logic [7:0]             mem [SIZE] = '{default: 8'h00};
    logic [3:0][AW-1:0]     laneAddr;
    logic [3:0][7:0]        byteData;
    logic [3:0]             byteWe;
    logic [31:0]            rdata;
    logic [31:0]            byteExt;
    logic [31:0]            halfExt;
    logic [31:0]            selIn [4];
    logic                   unusedAddrHi;

    assign unusedAddrHi = ^addr[31:AW];

    // Lane k is byte a+k; the AW-bit sum gives the modulo-SIZE wrap for free.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            laneAddr[k] = addr[AW-1:0] + AW'(k);
        end
    end

    assign rdata = {mem[laneAddr[0]], mem[laneAddr[1]], mem[laneAddr[2]], mem[laneAddr[3]]};

    extender #(.inN(8), .outN(32)) uByteExt (
        .in   (rdata[31:24]),
        .sign (load_ext),
        .out  (byteExt)
    );

    extender #(.inN(16), .outN(32)) uHalfExt (
        .in   (rdata[31:16]),
        .sign (load_ext),
        .out  (halfExt)
    );

    // Mux inputs ordered so dsize indexes them directly.
    assign selIn[0] = byteExt;
    assign selIn[1] = halfExt;
    assign selIn[2] = 32'd0;
    assign selIn[3] = rdata;
    assign dmem_out = selIn[dsize];

    always_comb begin
        byteWe   = 4'b0000;
        byteData = '0;
        case (dsize)
            DSIZE_BYTE: begin
                byteWe      = 4'b0001;
                byteData[0] = wdata[7:0];
            end
            DSIZE_HALF: begin
                byteWe      = 4'b0011;
                byteData[0] = wdata[15:8];
                byteData[1] = wdata[7:0];
            end
            DSIZE_WORD: begin
                byteWe      = 4'b1111;
                byteData[0] = wdata[31:24];
                byteData[1] = wdata[23:16];
                byteData[2] = wdata[15:8];
                byteData[3] = wdata[7:0];
            end
            default: begin
                byteWe = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && mem_wr) begin
            for (int k = 0; k < 4; k++) begin
                if (byteWe[k]) begin
                    mem[laneAddr[k]] <= byteData[k];
                end
            end
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign = ((dsize == DSIZE_HALF) && addr[0]) ||
                      ((dsize == DSIZE_WORD) && (addr[1:0] != 2'b00));

    // No load-intent input exists, so only misaligned stores set the flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            align_err <= 1'b0;
        end else if (misalign && mem_wr) begin
            align_err <= 1'b1;
        end
    end
`else
    assign misalign  = 1'b0;
    assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed self-checking bench for dmem_access_unit.
module tb_dmem_access_unit;

    localparam int SIZE = 16384;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam logic [31:0] EXP_MIS = 32'd1;
`else
    localparam logic [31:0] EXP_MIS = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_wr;
    logic [1:0]  dsize;
    logic        load_ext;
    logic [31:0] dmem_out;
    logic        misalign;
    logic        align_err;

    int errCnt = 0;
    int chkCnt = 0;

    dmem_access_unit dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .wdata     (wdata),
        .mem_wr    (mem_wr),
        .dsize     (dsize),
        .load_ext  (load_ext),
        .dmem_out  (dmem_out),
        .misalign  (misalign),
        .align_err (align_err)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chkCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic setAcc(input logic [31:0] a, input logic [1:0] sz, input logic ext,
                          input logic wr, input logic [31:0] wd);
        addr     = a;
        dsize    = sz;
        load_ext = ext;
        mem_wr   = wr;
        wdata    = wd;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                        input logic ext, input logic [31:0] exp);
        setAcc(a, sz, ext, 1'b0, 32'h0);
        checkVal(tag, dmem_out, exp);
    endtask

    initial begin
        reset = 1'b1;
        setAcc(32'h0, 2'b11, 1'b0, 1'b0, 32'h0);
        step();
        checkVal("rst_align_err", {31'd0, align_err}, 32'd0);
        load("init_zero", 32'h0, 2'b11, 1'b0, 32'h0);
        reset = 1'b0;

        // word store: same-cycle load sees old data
        setAcc(32'h10, 2'b11, 1'b0, 1'b1, 32'h89ABCDEF);
        checkVal("raw_old", dmem_out, 32'h0);
        checkVal("mis_aligned_word", {31'd0, misalign}, 32'd0);
        step();
        load("word_ld", 32'h10, 2'b11, 1'b0, 32'h89ABCDEF);
        load("m10", 32'h10, 2'b00, 1'b0, 32'h89);
        load("m13", 32'h13, 2'b00, 1'b0, 32'hEF);
        load("byte_sx", 32'h11, 2'b00, 1'b1, 32'hFFFFFFAB);
        load("byte_zx", 32'h11, 2'b00, 1'b0, 32'h000000AB);
        load("word_ext_ign", 32'h10, 2'b11, 1'b1, 32'h89ABCDEF);

        // half store preserves neighbours, upper wdata ignored
        setAcc(32'h12, 2'b01, 1'b0, 1'b1, 32'hFFFF1234);
        step();
        load("half_nbr", 32'h10, 2'b11, 1'b0, 32'h89AB1234);
        load("half_sx_pos", 32'h12, 2'b01, 1'b1, 32'h00001234);
        load("half_sx_neg", 32'h10, 2'b01, 1'b1, 32'hFFFF89AB);
        load("half_zx", 32'h10, 2'b01, 1'b0, 32'h000089AB);

        setAcc(32'h10, 2'b00, 1'b0, 1'b1, 32'hFFFFFFC5);
        step();
        load("byte_st", 32'h10, 2'b11, 1'b0, 32'hC5AB1234);

        // reserved size: no write, zero output
        setAcc(32'h10, 2'b10, 1'b1, 1'b1, 32'hFFFFFFFF);
        checkVal("rsvd_out", dmem_out, 32'h0);
        step();
        load("rsvd_nowr", 32'h10, 2'b11, 1'b0, 32'hC5AB1234);

        // reset suppresses writes
        reset = 1'b1;
        setAcc(32'h20, 2'b11, 1'b0, 1'b1, 32'hA5A5A5A5);
        step();
        reset = 1'b0;
        load("rst_nowr", 32'h20, 2'b11, 1'b0, 32'h0);
        checkVal("rst_err0", {31'd0, align_err}, 32'd0);

        load("upper_ign", 32'hFFFF0010, 2'b11, 1'b0, 32'hC5AB1234);

        // misalign detection; loads alone never set align_err
        setAcc(32'h13, 2'b01, 1'b0, 1'b0, 32'h0);
        checkVal("mis_half", {31'd0, misalign}, EXP_MIS);
        setAcc(32'h12, 2'b11, 1'b0, 1'b0, 32'h0);
        checkVal("mis_word", {31'd0, misalign}, EXP_MIS);
        setAcc(32'h13, 2'b00, 1'b0, 1'b0, 32'h0);
        checkVal("mis_byte", {31'd0, misalign}, 32'd0);
        setAcc(32'h12, 2'b01, 1'b0, 1'b0, 32'h0);
        checkVal("mis_half_ok", {31'd0, misalign}, 32'd0);
        setAcc(32'h11, 2'b11, 1'b0, 1'b0, 32'h0);
        step();
        checkVal("ld_no_err", {31'd0, align_err}, 32'd0);

        // wrapping misaligned word store
        setAcc(SIZE - 2, 2'b11, 1'b0, 1'b1, 32'hDEADBEEF);
        checkVal("mis_wrap", {31'd0, misalign}, EXP_MIS);
        step();
        checkVal("err_set", {31'd0, align_err}, EXP_MIS);
        load("wrap_hi", SIZE - 2, 2'b00, 1'b0, 32'hDE);
        load("wrap_lo", 32'h1, 2'b00, 1'b0, 32'hEF);
        load("wrap_word", SIZE - 2, 2'b11, 1'b0, 32'hDEADBEEF);
        load("wrap_w0", 32'h0, 2'b11, 1'b0, 32'hBEEF0000);

        // sticky until reset; reset beats a simultaneous set
        setAcc(32'h40, 2'b11, 1'b0, 1'b1, 32'h11223344);
        step();
        mem_wr = 1'b0;
        step();
        checkVal("err_sticky", {31'd0, align_err}, EXP_MIS);
        reset = 1'b1;
        setAcc(32'h41, 2'b01, 1'b0, 1'b1, 32'h0000FFFF);
        step();
        checkVal("rst_wins", {31'd0, align_err}, 32'd0);
        reset = 1'b0;
        load("rst_nowr2", 32'h40, 2'b11, 1'b0, 32'h11223344);
        step();
        checkVal("err_clear", {31'd0, align_err}, 32'd0);

        setAcc(32'h41, 2'b01, 1'b0, 1'b1, 32'h00005566);
        step();
        checkVal("err_half", {31'd0, align_err}, EXP_MIS);
        load("mis_half_st", 32'h40, 2'b11, 1'b0, 32'h11556644);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
